// File: rtl/param_lifo_stack_if.sv
// Command/response interface for param_lifo_stack.
// master: drives cmd_valid/cmd_op/cmd_ext/cmd_data, observes everything else.
// slave : the stack itself; drives cmd_ready, rsp_valid/rsp_data/rsp_err,
//         top_data, count, empty, full, err_ovf, err_unf.
interface param_lifo_stack_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 64
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             cmd_valid;
  logic [1:0]       cmd_op;
  logic             cmd_ext;
  logic [WIDTH-1:0] cmd_data;
  logic             cmd_ready;
  logic             rsp_valid;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_err;
  logic [WIDTH-1:0] top_data;
  logic [CW-1:0]    count;
  logic             empty;
  logic             full;
  logic             err_ovf;
  logic             err_unf;

  modport master (
    output cmd_valid, cmd_op, cmd_ext, cmd_data,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err, top_data, count,
           empty, full, err_ovf, err_unf
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_ext, cmd_data,
    output cmd_ready, rsp_valid, rsp_data, rsp_err, top_data, count,
           empty, full, err_ovf, err_unf
  );
endinterface

// File: rtl/param_lifo_stack.sv
// Parametrised LIFO stack (WIDTH-bit entries, DEPTH entries) with PUSH, POP
// and atomic REPLACE, a registered pop response and sticky error flags.
// Ports: clk, rst (sync, active-high), bus (param_lifo_stack_if.slave):
//   cmd_valid/cmd_op/cmd_ext/cmd_data in, cmd_ready out (= !rst),
//   rsp_valid/rsp_data/rsp_err pop response, top_data, count, empty, full,
//   err_ovf, err_unf status.
// Optional macro STACK_EXT_OPS_EN: cmd_ext=1 selects DUP/SWAP/CLEAR; when
// undefined cmd_ext is ignored.
// The top entry is held in a register (and mirrored in mem) so an op issued
// right after a push sees the new top without a RAM read-after-write.
module param_lifo_stack #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 64
) (
  input logic               clk,
  input logic               rst,
  param_lifo_stack_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {
    OP_NOP  = 2'b00,
    OP_PUSH = 2'b01,
    OP_POP  = 2'b10,
    OP_REPL = 2'b11
  } op_e;

  logic [WIDTH-1:0] mem [DEPTH];

  logic [CW-1:0]    count_p1, count_n;
  logic [WIDTH-1:0] top_p1, top_n;
  logic             rsp_vld_p1, rsp_vld_n;
  logic [WIDTH-1:0] rsp_data_p1, rsp_data_n;
  logic             rsp_err_p1, rsp_err_n;
  logic             err_ovf_p1, err_ovf_n;
  logic             err_unf_p1, err_unf_n;
  logic             empty_p1, full_p1;

  logic             we_a, we_b;
  logic [AW-1:0]    wa_a, wa_b;
  logic [WIDTH-1:0] wd_a, wd_b;

  logic             is_empty, is_full;
  logic [CW-1:0]    cnt_dec, cnt_dec2;
  logic [AW-1:0]    idx_free, idx_top, idx_below;
  logic [WIDTH-1:0] below;
  op_e              op;

  assign is_empty  = (count_p1 == '0);
  assign is_full   = (count_p1 == FULL_CNT);
  assign cnt_dec   = count_p1 - CW'(1);
  assign cnt_dec2  = count_p1 - CW'(2);
  assign idx_free  = count_p1[AW-1:0];
  assign idx_top   = cnt_dec[AW-1:0];
  assign idx_below = cnt_dec2[AW-1:0];
  assign below     = mem[idx_below];
  assign op        = op_e'(bus.cmd_op);

`ifndef STACK_EXT_OPS_EN
  logic unused_ext;
  assign unused_ext = bus.cmd_ext;
`endif

  always_comb begin
    count_n    = count_p1;
    top_n      = top_p1;
    rsp_vld_n  = 1'b0;
    rsp_data_n = '0;
    rsp_err_n  = 1'b0;
    err_ovf_n  = err_ovf_p1;
    err_unf_n  = err_unf_p1;
    we_a       = 1'b0;
    wa_a       = '0;
    wd_a       = '0;
    we_b       = 1'b0;
    wa_b       = '0;
    wd_b       = '0;
    if (bus.cmd_valid) begin
`ifdef STACK_EXT_OPS_EN
      if (bus.cmd_ext) begin
        case (op)
          OP_PUSH: begin // DUP
            if (is_full) begin
              err_ovf_n = 1'b1;
            end else if (is_empty) begin
              err_unf_n = 1'b1;
            end else begin
              we_a    = 1'b1;
              wa_a    = idx_free;
              wd_a    = top_p1;
              count_n = count_p1 + CW'(1);
            end
          end
          OP_POP: begin // SWAP
            if (count_p1 < CW'(2)) begin
              err_unf_n = 1'b1;
            end else begin
              we_a  = 1'b1;
              wa_a  = idx_top;
              wd_a  = below;
              we_b  = 1'b1;
              wa_b  = idx_below;
              wd_b  = top_p1;
              top_n = below;
            end
          end
          OP_REPL: begin // CLEAR
            count_n = '0;
            top_n   = '0;
          end
          default: ;
        endcase
      end else
`endif
      begin
        case (op)
          OP_PUSH: begin
            if (is_full) begin
              err_ovf_n = 1'b1;
            end else begin
              we_a    = 1'b1;
              wa_a    = idx_free;
              wd_a    = bus.cmd_data;
              count_n = count_p1 + CW'(1);
              top_n   = bus.cmd_data;
            end
          end
          OP_POP: begin
            rsp_vld_n = 1'b1;
            if (is_empty) begin
              rsp_err_n = 1'b1;
              err_unf_n = 1'b1;
            end else begin
              rsp_data_n = top_p1;
              count_n    = cnt_dec;
              top_n      = (count_p1 >= CW'(2)) ? below : '0;
            end
          end
          OP_REPL: begin
            rsp_vld_n = 1'b1;
            we_a      = 1'b1;
            wd_a      = bus.cmd_data;
            top_n     = bus.cmd_data;
            if (is_empty) begin
              // Empty replace degenerates to a push with an error response.
              rsp_err_n = 1'b1;
              err_unf_n = 1'b1;
              wa_a      = idx_free;
              count_n   = CW'(1);
            end else begin
              rsp_data_n = top_p1;
              wa_a       = idx_top;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // ---- stage p1: registered state and outputs ----
  always_ff @(posedge clk) begin
    if (rst) begin
      count_p1    <= '0;
      top_p1      <= '0;
      rsp_vld_p1  <= 1'b0;
      rsp_data_p1 <= '0;
      rsp_err_p1  <= 1'b0;
      err_ovf_p1  <= 1'b0;
      err_unf_p1  <= 1'b0;
      empty_p1    <= 1'b1;
      full_p1     <= 1'b0;
    end else begin
      count_p1    <= count_n;
      top_p1      <= top_n;
      rsp_vld_p1  <= rsp_vld_n;
      rsp_data_p1 <= rsp_data_n;
      rsp_err_p1  <= rsp_err_n;
      err_ovf_p1  <= err_ovf_n;
      err_unf_p1  <= err_unf_n;
      empty_p1    <= (count_n == '0);
      full_p1     <= (count_n == FULL_CNT);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && we_a) mem[wa_a] <= wd_a;
    if (!rst && we_b) mem[wa_b] <= wd_b;
  end

  assign bus.cmd_ready = !rst;
  assign bus.rsp_valid = rsp_vld_p1;
  assign bus.rsp_data  = rsp_data_p1;
  assign bus.rsp_err   = rsp_err_p1;
  assign bus.top_data  = top_p1;
  assign bus.count     = count_p1;
  assign bus.empty     = empty_p1;
  assign bus.full      = full_p1;
  assign bus.err_ovf   = err_ovf_p1;
  assign bus.err_unf   = err_unf_p1;
endmodule

// File: tb/tb_param_lifo_stack.sv
// Directed scoreboard bench for param_lifo_stack (WIDTH=8, DEPTH=4).
// Stimulus pushes expected pop responses into exp_q; the monitor pops and
// compares on every rsp_valid. State outputs are checked after each command.
module tb_param_lifo_stack;
  localparam int W = 8;
  localparam int D = 4;

  localparam logic [1:0] NOP  = 2'b00;
  localparam logic [1:0] PUSH = 2'b01;
  localparam logic [1:0] POP  = 2'b10;
  localparam logic [1:0] REPL = 2'b11;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  logic [W:0] exp_q [$];

  always #5 clk = ~clk;

  param_lifo_stack_if #(.WIDTH(W), .DEPTH(D)) bus ();

  param_lifo_stack #(.WIDTH(W), .DEPTH(D)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic expect_rsp(input logic err, input logic [W-1:0] d);
    exp_q.push_back({err, d});
  endtask

  // Drive one command for one clock; outputs are valid on return.
  task automatic step(input logic [1:0] op, input logic [W-1:0] d, input logic ext = 1'b0);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_ext   = ext;
    bus.cmd_data  = d;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_ext   = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.cmd_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (bus.rsp_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rsp_unexpected actual=%0b_%0h required=none", bus.rsp_err, bus.rsp_data);
      end else begin
        logic [W:0] e;
        e = exp_q.pop_front();
        if ({bus.rsp_err, bus.rsp_data} !== e) begin
          errors++;
          $display("FAIL rsp actual=%0b_%0h required=%0b_%0h",
                   bus.rsp_err, bus.rsp_data, e[W], e[W-1:0]);
        end
      end
    end
  end

  initial begin
    // Reset with a command present: it must be ignored.
    rst           = 1'b1;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = POP;
    bus.cmd_ext   = 1'b0;
    bus.cmd_data  = 8'h77;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(bus.cmd_ready), 0);
    chk("rst_count", 32'(bus.count), 0);
    chk("rst_empty", 32'(bus.empty), 1);
    chk("rst_full", 32'(bus.full), 0);
    chk("rst_top", 32'(bus.top_data), 0);
    chk("rst_flags", 32'({bus.err_ovf, bus.err_unf}), 0);
    chk("rst_rsp", 32'(bus.rsp_valid), 0);
    rst           = 1'b0;
    bus.cmd_valid = 1'b0;
    #1;
    chk("ready_after_rst", 32'(bus.cmd_ready), 1);
    idle(1);

    // Fill.
    step(PUSH, 8'h11);
    chk("push1_top", 32'(bus.top_data), 32'h11);
    step(PUSH, 8'h22);
    step(PUSH, 8'h33);
    step(PUSH, 8'h44);
    chk("fill_count", 32'(bus.count), 4);
    chk("fill_full", 32'(bus.full), 1);
    chk("fill_top", 32'(bus.top_data), 32'h44);

    // Overflow.
    step(PUSH, 8'h55);
    chk("ovf_count", 32'(bus.count), 4);
    chk("ovf_flag", 32'(bus.err_ovf), 1);
    chk("ovf_top", 32'(bus.top_data), 32'h44);

    // Replace while full.
    expect_rsp(1'b0, 8'h44);
    step(REPL, 8'h66);
    chk("repl_full_count", 32'(bus.count), 4);
    chk("repl_full_top", 32'(bus.top_data), 32'h66);

    // Drain.
    expect_rsp(1'b0, 8'h66);
    step(POP, 8'h00);
    chk("pop1_top", 32'(bus.top_data), 32'h33);
    chk("pop1_count", 32'(bus.count), 3);
    expect_rsp(1'b0, 8'h33);
    step(POP, 8'h00);
    expect_rsp(1'b0, 8'h22);
    step(POP, 8'h00);
    expect_rsp(1'b0, 8'h11);
    step(POP, 8'h00);
    chk("drain_empty", 32'(bus.empty), 1);
    chk("drain_top", 32'(bus.top_data), 0);
    chk("ovf_sticky", 32'(bus.err_ovf), 1);

    // Underflow.
    expect_rsp(1'b1, 8'h00);
    step(POP, 8'h00);
    chk("unf_flag", 32'(bus.err_unf), 1);
    chk("unf_count", 32'(bus.count), 0);

    // Replace on a partly filled stack.
    step(PUSH, 8'h11);
    step(PUSH, 8'h22);
    expect_rsp(1'b0, 8'h22);
    step(REPL, 8'h99);
    chk("repl_top", 32'(bus.top_data), 32'h99);
    chk("repl_count", 32'(bus.count), 2);
    expect_rsp(1'b0, 8'h99);
    step(POP, 8'h00);
    chk("repl_pop_top", 32'(bus.top_data), 32'h11);
    expect_rsp(1'b0, 8'h11);
    step(POP, 8'h00);

    // Back-to-back push then pop.
    step(PUSH, 8'hA5);
    expect_rsp(1'b0, 8'hA5);
    step(POP, 8'h00);
    chk("b2b_count", 32'(bus.count), 0);

    // Replace on empty acts as push with an error response.
    expect_rsp(1'b1, 8'h00);
    step(REPL, 8'h3C);
    chk("repl_empty_count", 32'(bus.count), 1);
    chk("repl_empty_top", 32'(bus.top_data), 32'h3C);
    expect_rsp(1'b0, 8'h3C);
    step(POP, 8'h00);

    // Reset mid-operation with a command present.
    step(PUSH, 8'h12);
    rst           = 1'b1;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = POP;
    bus.cmd_data  = 8'h34;
    @(posedge clk);
    #1;
    rst           = 1'b0;
    bus.cmd_valid = 1'b0;
    chk("midrst_count", 32'(bus.count), 0);
    chk("midrst_top", 32'(bus.top_data), 0);
    chk("midrst_flags", 32'({bus.err_ovf, bus.err_unf}), 0);
    chk("midrst_empty", 32'(bus.empty), 1);
    idle(1);

`ifdef STACK_EXT_OPS_EN
    step(PUSH, 8'h11);
    step(POP, 8'h00, 1'b1);            // SWAP with one entry
    chk("swap1_unf", 32'(bus.err_unf), 1);
    chk("swap1_count", 32'(bus.count), 1);
    chk("swap1_top", 32'(bus.top_data), 32'h11);
    step(PUSH, 8'h22);
    step(POP, 8'h00, 1'b1);            // SWAP -> {22,11}
    chk("swap_top", 32'(bus.top_data), 32'h11);
    chk("swap_count", 32'(bus.count), 2);
    step(PUSH, 8'h00, 1'b1);           // DUP -> {22,11,11}
    chk("dup_top", 32'(bus.top_data), 32'h11);
    chk("dup_count", 32'(bus.count), 3);
    expect_rsp(1'b0, 8'h11);
    step(POP, 8'h00);
    expect_rsp(1'b0, 8'h11);
    step(POP, 8'h00);
    expect_rsp(1'b0, 8'h22);
    step(POP, 8'h00);
    step(PUSH, 8'h33);
    step(REPL, 8'h00, 1'b1);           // CLEAR
    chk("clear_empty", 32'(bus.empty), 1);
    chk("clear_top", 32'(bus.top_data), 0);
    step(PUSH, 8'h00, 1'b1);           // DUP on empty
    chk("dup_empty_count", 32'(bus.count), 0);
    step(PUSH, 8'h01);
    step(PUSH, 8'h02);
    step(PUSH, 8'h03);
    step(PUSH, 8'h04);
    step(PUSH, 8'h00, 1'b1);           // DUP on full
    chk("dup_full_ovf", 32'(bus.err_ovf), 1);
    chk("dup_full_count", 32'(bus.count), 4);
    chk("dup_full_top", 32'(bus.top_data), 32'h04);
`else
    // cmd_ext must be ignored.
    step(PUSH, 8'h5A, 1'b1);
    chk("ext_push_count", 32'(bus.count), 1);
    chk("ext_push_top", 32'(bus.top_data), 32'h5A);
    expect_rsp(1'b0, 8'h5A);
    step(REPL, 8'h6B, 1'b1);
    chk("ext_repl_top", 32'(bus.top_data), 32'h6B);
    expect_rsp(1'b0, 8'h6B);
    step(POP, 8'h00, 1'b1);
    chk("ext_pop_empty", 32'(bus.empty), 1);
`endif

    step(NOP, 8'hFF);
    chk("nop_rsp", 32'(bus.rsp_valid), 0);
    idle(3);
    chk("rsp_outstanding", 32'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
